// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
// FSM encoding, width helper and output polarity constants.
package sseg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam bit POL_ACTIVE_HIGH = 1'b0;
    localparam bit POL_ACTIVE_LOW  = 1'b1;

    // $clog2 returns 0 for a single digit; an index still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sseg_pwm_slot.sv
// Per-slot phase counter and PWM compare for one digit slot of 2**BRIGHT_W ticks.
// The first DEAD_TICKS phases of every slot are forced dark to stop ghosting.
module sseg_pwm_slot
    import sseg_pkg::*;
#(
    parameter int BRIGHT_W   = 8,
    parameter int DEAD_TICKS = 2
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic                clr_i,
    input  logic                tick_i,
    input  logic [BRIGHT_W-1:0] brightness_i,
    output logic                lit_o,
    output logic                slot_end_o
);

    localparam logic [BRIGHT_W-1:0] PHASE_MAX = '1;
    localparam logic [BRIGHT_W:0]   DEAD      = (BRIGHT_W+1)'(DEAD_TICKS);

    logic [BRIGHT_W-1:0] phase_q;
    logic [BRIGHT_W:0]   phase_ext;

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            phase_q <= '0;
        end else if (clr_i) begin
            phase_q <= '0;
        end else if (tick_i) begin
            phase_q <= (phase_q == PHASE_MAX) ? '0 : phase_q + 1'b1;
        end
    end

    // Extra bit keeps the subtraction and compare free of wrap-around.
    always_comb begin
        phase_ext  = {1'b0, phase_q};
        lit_o      = (phase_ext >= DEAD) && ((phase_ext - DEAD) < {1'b0, brightness_i});
        slot_end_o = tick_i & ~clr_i & (phase_q == PHASE_MAX);
    end

endmodule

// File: rtl/sseg_mux_ctrl.sv
// Multiplexed seven-segment driver: digit scan, PWM brightness, dead time, frame shadowing.
// Optional blink feature is built when SSEG_MUX_BLINK_EN is defined.
module sseg_mux_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int N_SEGS         = 8,
    parameter int DIV_W          = 16,
    parameter int BRIGHT_W       = 8,
    parameter int DEAD_TICKS     = 2,
    parameter bit SEG_ACTIVE_LOW = POL_ACTIVE_HIGH,
    parameter bit SEL_ACTIVE_LOW = POL_ACTIVE_HIGH
) (
    input  logic                             clk_i,
    input  logic                             async_rst_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic [DIV_W-1:0]                 clk_div_i,
    input  logic [N_DIGITS*BRIGHT_W-1:0]     brightness_i,
    input  logic [N_DIGITS*N_SEGS-1:0]       segments_i,
`ifdef SSEG_MUX_BLINK_EN
    input  logic [N_DIGITS-1:0]              blink_mask_i,
    input  logic [7:0]                       blink_div_i,
`endif
    output logic [N_SEGS-1:0]                seg_o,
    output logic [N_DIGITS-1:0]              seg_sel_o,
    output logic [clog2_min1(N_DIGITS)-1:0]  digit_o,
    output logic                             sync_o
);

    localparam int                DIG_W    = clog2_min1(N_DIGITS);
    localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(N_DIGITS - 1);
    localparam logic [N_SEGS-1:0] SEG_POL  = {N_SEGS{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] SEL_POL = {N_DIGITS{SEL_ACTIVE_LOW}};

    state_t                        state_q, state_d;
    logic [DIV_W-1:0]              div_cnt_q;
    logic [DIG_W-1:0]              digit_q;
    logic                          first_q;
    logic [N_DIGITS*N_SEGS-1:0]    seg_shadow_q;
    logic [N_DIGITS*BRIGHT_W-1:0]  bright_shadow_q;

    logic                run, clr, tick, lit, slot_end, wrap, load, show, blink_dark;
    logic [N_SEGS-1:0]   cur_seg, seg_raw;
    logic [BRIGHT_W-1:0] cur_bright;
    logic [N_DIGITS-1:0] sel_raw;

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i)  state_d = ST_RUN;
            ST_RUN:  if (!enable_i) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
        if (rst_i) state_d = ST_IDLE;
    end

    // clr covers both resets and the RUN -> IDLE exit: everything restarts at digit 0.
    always_comb begin
        run        = (state_q == ST_RUN);
        clr        = rst_i | ~enable_i;
        tick       = run & (div_cnt_q == '0);
        wrap       = slot_end & (digit_q == DIG_LAST);
        load       = tick & ~clr & (first_q | wrap);
        show       = run & ~clr;
        cur_seg    = seg_shadow_q[int'(digit_q)*N_SEGS +: N_SEGS];
        cur_bright = bright_shadow_q[int'(digit_q)*BRIGHT_W +: BRIGHT_W];
        seg_raw    = (show & lit & ~blink_dark) ? cur_seg : '0;
        sel_raw    = show ? (N_DIGITS'(1) << digit_q) : '0;
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            div_cnt_q <= '0;
            digit_q   <= '0;
            first_q   <= 1'b0;
        end else if (clr) begin
            div_cnt_q <= '0;
            digit_q   <= '0;
            first_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) first_q <= 1'b1;
            else if (tick)          first_q <= 1'b0;
            if (tick)     div_cnt_q <= clk_div_i;
            else if (run) div_cnt_q <= div_cnt_q - 1'b1;
            if (slot_end) digit_q <= (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            seg_shadow_q    <= '0;
            bright_shadow_q <= '0;
        end else if (rst_i) begin
            seg_shadow_q    <= '0;
            bright_shadow_q <= '0;
        end else if (load) begin
            seg_shadow_q    <= segments_i;
            bright_shadow_q <= brightness_i;
        end
    end

    sseg_pwm_slot #(
        .BRIGHT_W   (BRIGHT_W),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_pwm_slot (
        .clk_i        (clk_i),
        .async_rst_i  (async_rst_i),
        .clr_i        (clr),
        .tick_i       (tick),
        .brightness_i (cur_bright),
        .lit_o        (lit),
        .slot_end_o   (slot_end)
    );

`ifdef SSEG_MUX_BLINK_EN
    logic [N_DIGITS-1:0] mask_shadow_q;
    logic [7:0]          frame_cnt_q;
    logic                blink_phase_q;

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            mask_shadow_q <= '0;
        end else if (rst_i) begin
            mask_shadow_q <= '0;
        end else if (load) begin
            mask_shadow_q <= blink_mask_i;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (clr) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (wrap) begin
            if (frame_cnt_q == blink_div_i) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign blink_dark = blink_phase_q & mask_shadow_q[digit_q];
`else
    assign blink_dark = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            seg_o     <= SEG_POL;
            seg_sel_o <= SEL_POL;
            digit_o   <= '0;
            sync_o    <= 1'b0;
        end else begin
            seg_o     <= seg_raw ^ SEG_POL;
            seg_sel_o <= sel_raw ^ SEL_POL;
            digit_o   <= show ? digit_q : '0;
            sync_o    <= wrap;
        end
    end

endmodule

// File: tb/tb_sseg_mux_ctrl.sv
// Bench for sseg_mux_ctrl: vector table, corner sequences and random run vs a tick-count model.
// Two instances share stimulus: active-high and active-low polarity.
module tb_sseg_mux_ctrl;
    import sseg_pkg::*;

    localparam int ND = 4;
    localparam int NS = 8;
    localparam int BW = 2;
    localparam int DT = 1;
    localparam int SLOT = 4;
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        async_rst = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] clk_div = 16'd1;
    logic [7:0]  brightness = '0;
    logic [31:0] segments = '0;
`ifdef SSEG_MUX_BLINK_EN
    logic [3:0]  blink_mask = '0;
    logic [7:0]  blink_div = '0;
`endif
    logic [7:0]  seg, seg_n;
    logic [3:0]  sel, sel_n;
    logic [1:0]  dig, dig_n;
    logic        sync, sync_n;

    sseg_mux_ctrl #(.N_DIGITS(ND), .N_SEGS(NS), .DIV_W(16), .BRIGHT_W(BW), .DEAD_TICKS(DT),
                    .SEG_ACTIVE_LOW(POL_ACTIVE_HIGH), .SEL_ACTIVE_LOW(POL_ACTIVE_HIGH)) dut (
        .clk_i(clk), .async_rst_i(async_rst), .rst_i(rst), .enable_i(enable),
        .clk_div_i(clk_div), .brightness_i(brightness), .segments_i(segments),
`ifdef SSEG_MUX_BLINK_EN
        .blink_mask_i(blink_mask), .blink_div_i(blink_div),
`endif
        .seg_o(seg), .seg_sel_o(sel), .digit_o(dig), .sync_o(sync));

    sseg_mux_ctrl #(.N_DIGITS(ND), .N_SEGS(NS), .DIV_W(16), .BRIGHT_W(BW), .DEAD_TICKS(DT),
                    .SEG_ACTIVE_LOW(POL_ACTIVE_LOW), .SEL_ACTIVE_LOW(POL_ACTIVE_LOW)) dut_n (
        .clk_i(clk), .async_rst_i(async_rst), .rst_i(rst), .enable_i(enable),
        .clk_div_i(clk_div), .brightness_i(brightness), .segments_i(segments),
`ifdef SSEG_MUX_BLINK_EN
        .blink_mask_i(blink_mask), .blink_div_i(blink_div),
`endif
        .seg_o(seg_n), .seg_sel_o(sel_n), .digit_o(dig_n), .sync_o(sync_n));

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: everything derives from the number of ticks since enable
    int         m_run, m_cnt, m_n, m_first;
    logic [7:0] m_seg [ND];
    int         m_br  [ND];
    logic [14:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_n = 0; m_first = 0;
        for (int d = 0; d < ND; d++) begin
            m_seg[d] = '0;
            m_br[d]  = 0;
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_seg"},    32'(seg),    32'h00);
        chk({name, "_sel"},    32'(sel),    32'h0);
        chk({name, "_dig"},    32'(dig),    32'h0);
        chk({name, "_sync"},   32'(sync),   32'h0);
        chk({name, "_seg_n"},  32'(seg_n),  32'hFF);
        chk({name, "_sel_n"},  32'(sel_n),  32'hF);
    endtask

    // driver: predict outputs for the coming edge, clock once, compare
    task automatic step();
        int phase, digit;
        bit show, tick_now;
        logic [7:0] e_seg, inv_seg;
        logic [3:0] e_sel, inv_sel;
        logic [1:0] e_dig;
        logic       e_sync;
        logic [14:0] e;
        phase    = m_n % SLOT;
        digit    = (m_n / SLOT) % ND;
        show     = (m_run != 0) && enable && !rst;
        e_sel    = show ? 4'(1 << digit) : 4'h0;
        e_dig    = show ? 2'(digit) : 2'd0;
        e_seg    = (show && phase >= DT && (phase - DT) < m_br[digit]) ? m_seg[digit] : 8'h00;
        tick_now = show && (m_cnt == 0);
        e_sync   = tick_now && (((m_n + 1) % FRAME) == 0);
        exp_q.push_back({e_seg, e_sel, e_dig, e_sync});
        if (rst) begin
            model_reset();
        end else if (!enable) begin
            m_run = 0; m_cnt = 0; m_n = 0; m_first = 0;
        end else if (m_run == 0) begin
            m_run = 1; m_cnt = 0; m_first = 1;
        end else if (tick_now) begin
            m_n++;
            m_cnt = int'(clk_div);
            if (m_first != 0 || (m_n % FRAME) == 0) begin
                for (int d = 0; d < ND; d++) begin
                    m_seg[d] = segments[d*NS +: NS];
                    m_br[d]  = int'(brightness[d*BW +: BW]);
                end
            end
            m_first = 0;
        end else begin
            m_cnt--;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        inv_seg = ~e[14:7];
        inv_sel = ~e[6:3];
        chk("seg",    32'(seg),    32'(e[14:7]));
        chk("sel",    32'(sel),    32'(e[6:3]));
        chk("digit",  32'(dig),    32'(e[2:1]));
        chk("sync",   32'(sync),   32'(e[0]));
        chk("seg_n",  32'(seg_n),  32'(inv_seg));
        chk("sel_n",  32'(sel_n),  32'(inv_sel));
        chk("digit_n", 32'(dig_n), 32'(e[2:1]));
        chk("sync_n", 32'(sync_n), 32'(e[0]));
    endtask

    task automatic wait_sync(input int budget, input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (sync !== 1'b1 && k < budget);
        if (sync !== 1'b1) chk({name, "_timeout"}, 32'(sync), 32'h1);
    endtask

    typedef struct {
        logic [31:0] seg;
        logic [7:0]  br;
        int          exp_lit [ND];
    } vec_t;

    vec_t vecs [5];
    int   lit_cnt [ND];
    int   sel_cnt [ND];
    int   sync_cnt, bad_cnt, k;
    bit   old_seen;

    initial begin
        vecs[0] = '{seg: 32'h08_04_02_01, br: 8'hFF, exp_lit: '{6, 6, 6, 6}};
        vecs[1] = '{seg: 32'h08_04_02_01, br: 8'h01, exp_lit: '{2, 0, 0, 0}};
        vecs[2] = '{seg: 32'h80_40_20_10, br: 8'h00, exp_lit: '{0, 0, 0, 0}};
        vecs[3] = '{seg: 32'hC0_30_0C_03, br: 8'h36, exp_lit: '{4, 2, 6, 0}};
        vecs[4] = '{seg: 32'hFF_FF_FF_FF, br: 8'hAA, exp_lit: '{4, 4, 4, 4}};
        model_reset();

        // reset state
        #1 async_rst = 1'b1;
        #2 chk_idle("reset");
        #9 async_rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // table-driven frame measurements
        for (int v = 0; v < 5; v++) begin
            enable = 1'b0;
            step();
            segments = vecs[v].seg;
            brightness = vecs[v].br;
            clk_div = 16'd1;
            enable = 1'b1;
            wait_sync(100, "tbl_sync");
            for (int d = 0; d < ND; d++) begin
                lit_cnt[d] = 0;
                sel_cnt[d] = 0;
            end
            sync_cnt = 0;
            bad_cnt = 0;
            for (int c = 0; c < 32; c++) begin
                step();
                if (sync) sync_cnt++;
                for (int d = 0; d < ND; d++) begin
                    if (sel[d]) begin
                        sel_cnt[d]++;
                        if (seg == vecs[v].seg[d*NS +: NS]) lit_cnt[d]++;
                        else if (seg != 8'h00) bad_cnt++;
                    end
                end
            end
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("tbl%0d_lit_d%0d", v, d), 32'(lit_cnt[d]), 32'(vecs[v].exp_lit[d]));
                chk($sformatf("tbl%0d_sel_d%0d", v, d), 32'(sel_cnt[d]), 32'd8);
            end
            chk($sformatf("tbl%0d_sync", v), 32'(sync_cnt), 32'd1);
            chk($sformatf("tbl%0d_badseg", v), 32'(bad_cnt), 32'd0);
        end

        // frame coherence: change data while digit 1 is on
        segments = 32'h08_04_02_01;
        brightness = 8'hFF;
        wait_sync(100, "coh_sync0");
        wait_sync(100, "coh_sync1");
        k = 0;
        while (dig !== 2'd1 && k < 40) begin
            step();
            k++;
        end
        chk("coh_reach_d1", 32'(dig), 32'd1);
        segments = 32'h88_44_22_11;
        old_seen = 1'b0;
        k = 0;
        do begin
            step();
            k++;
            if (sel == 4'b0100 && seg == 8'h04) old_seen = 1'b1;
        end while (sync !== 1'b1 && k < 64);
        chk("coh_old_d2", 32'(old_seen), 32'h1);
        chk("coh_sync2", 32'(sync), 32'h1);
        k = 0;
        do begin
            step();
            k++;
        end while (seg == 8'h00 && k < 20);
        chk("coh_new_delay", 32'(k), 32'd3);
        chk("coh_new_val", 32'(seg), 32'h11);
        chk("coh_new_sel", 32'(sel), 32'b0001);

        // enable drop mid-slot, then re-enable
        k = 0;
        while (!(sel == 4'b0100 && seg != 8'h00) && k < 64) begin
            step();
            k++;
        end
        chk("dis_reach_d2", 32'(sel), 32'b0100);
        enable = 1'b0;
        step();
        chk_idle("dis");
        enable = 1'b1;
        step();
        chk_idle("reen0");
        step();
        chk("reen_sel", 32'(sel), 32'b0001);
        chk("reen_dig", 32'(dig), 32'd0);
        chk("reen_seg", 32'(seg), 32'h00);

        // async reset right while sync is high
        wait_sync(100, "ar_sync");
        #2 async_rst = 1'b1;
        #1 chk_idle("arst");
        model_reset();
        @(posedge clk);
        #3 async_rst = 1'b0;
        for (int i = 0; i < 40; i++) step();

        // random stimulus
        for (int i = 0; i < 2000; i++) begin
            rst = 1'b0;
            if ($urandom_range(0, 39) == 0) segments = $urandom;
            if ($urandom_range(0, 39) == 0) brightness = 8'($urandom);
            if ($urandom_range(0, 199) == 0) clk_div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
